// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size the digit counter.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_serial_adder_ripple_slice.sv
// Combinational DIGIT-bit ripple-carry slice; the only adder hardware in the
// digit-serial datapath.
module ripple_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] s_o,
    output logic             cout_o
);

    logic carry;

    always_comb begin
        s_o   = '0;
        carry = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock through one ripple slice.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
`ifdef ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0] sliceS;
    logic             sliceCout;
    logic             lastDigit;
    int               digitBase;

    ripple_slice #(.DIGIT(DIGIT)) uSlice (
        .a_i    (aSh_q[DIGIT-1:0]),
        .b_i    (bSh_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .s_o    (sliceS),
        .cout_o (sliceCout)
    );

    assign lastDigit = (cnt_q == CW'(N - 1));
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

    // Operands shift right so the current digit always sits in the low DIGIT bits;
    // on the final digit those low bits carry the original sign bits for ovf.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aSh_d     = aSh_q;
        bSh_d     = bSh_q;
        carry_d   = carry_q;
        s_d       = s_q;
        cout_d    = cout_q;
`ifdef ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        digitBase = int'(cnt_q) * DIGIT;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
`ifdef ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[digitBase +: DIGIT] = sliceS;
                carry_d = sliceCout;
                aSh_d   = aSh_q >> DIGIT;
                bSh_d   = bSh_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (lastDigit) begin
                    cout_d  = sliceCout;
`ifdef ADDER_OVF_EN
                    ovf_d   = (aSh_q[DIGIT-1] == bSh_q[DIGIT-1]) &&
                              (sliceS[DIGIT-1] != aSh_q[DIGIT-1]);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            aSh_q   <= '0;
            bSh_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: 16/4 directed cases plus a 4-bit
// exhaustive sweep on DIGIT=1 and DIGIT=4 instances. ovf checked with ADDER_OVF_EN.
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t mainQ[$];
    exp_t sw1Q[$];
    exp_t sw4Q[$];

    logic        rst, inValid, inReady, cinIn, outValid, outReady, coutOut;
    logic [15:0] aIn, bIn, sOut;
    logic        swValid, swCin, swReady;
    logic [3:0]  swA, swB;
    logic        inReady1, outValid1, cout1, inReady4, outValid4, cout4;
    logic [3:0]  s1, s4;
    logic [4:0]  swSum;
    int          lat;
`ifdef ADDER_OVF_EN
    logic        ovfOut, ovf1, ovf4;
`endif

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .a(aIn), .b(bIn), .cin(cinIn), .out_valid(outValid), .out_ready(outReady),
`ifdef ADDER_OVF_EN
        .ovf(ovfOut),
`endif
        .s(sOut), .cout(coutOut)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dutSw1 (
        .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(inReady1),
        .a(swA), .b(swB), .cin(swCin), .out_valid(outValid1), .out_ready(swReady),
`ifdef ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .s(s1), .cout(cout1)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(4)) dutSw4 (
        .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(inReady4),
        .a(swA), .b(swB), .cin(swCin), .out_valid(outValid4), .out_ready(swReady),
`ifdef ADDER_OVF_EN
        .ovf(ovf4),
`endif
        .s(s4), .cout(cout4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitors pop one expectation per completed output handshake.
    always @(negedge clk) begin : monMain
        exp_t e;
        if (!rst && outValid && outReady) begin
            if (mainQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL main_unexpected actual=%0h expected=none", sOut);
            end else begin
                e = mainQ.pop_front();
                checkOutput("main_s", sOut, e.s);
                checkOutput("main_cout", coutOut, e.cout);
`ifdef ADDER_OVF_EN
                checkOutput("main_ovf", ovfOut, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin : monSw1
        exp_t e;
        if (!rst && outValid1 && swReady) begin
            if (sw1Q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sw1_unexpected actual=%0h expected=none", s1);
            end else begin
                e = sw1Q.pop_front();
                checkOutput("sw1_s", s1, e.s);
                checkOutput("sw1_cout", cout1, e.cout);
`ifdef ADDER_OVF_EN
                checkOutput("sw1_ovf", ovf1, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin : monSw4
        exp_t e;
        if (!rst && outValid4 && swReady) begin
            if (sw4Q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sw4_unexpected actual=%0h expected=none", s4);
            end else begin
                e = sw4Q.pop_front();
                checkOutput("sw4_s", s4, e.s);
                checkOutput("sw4_cout", cout4, e.cout);
`ifdef ADDER_OVF_EN
                checkOutput("sw4_ovf", ovf4, e.ovf);
`endif
            end
        end
    end

    // Called just after a rising edge; issues one operand transfer to the 16-bit DUT.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                 input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            if (inReady) break;
            @(posedge clk);
            #1;
        end
        checkOutput("apply_in_ready", inReady, 1'b1);
        aIn     = av;
        bIn     = bv;
        cinIn   = cv;
        inValid = 1'b1;
        e.s     = es;
        e.cout  = ec;
        e.ovf   = eo;
        mainQ.push_back(e);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid, checking in_ready stays low.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (outValid) break;
            checkOutput("busy_in_ready", inReady, 1'b0);
        end
        checkOutput("result_out_valid", outValid, 1'b1);
        checkOutput("done_in_ready", inReady, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; inValid = 1'b0; aIn = '0; bIn = '0; cinIn = 1'b0; outReady = 1'b1;
        swValid = 1'b0; swA = '0; swB = '0; swCin = 1'b0; swReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", inReady, 1'b1);
        checkOutput("reset_out_valid", outValid, 1'b0);
        checkOutput("reset_s", sOut, 16'h0000);
        checkOutput("reset_cout", coutOut, 1'b0);
`ifdef ADDER_OVF_EN
        checkOutput("reset_ovf", ovfOut, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] carry through all digits");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitResult(lat);
        checkOutput("t1_latency", lat, 4);
        @(posedge clk);
        #1;
        checkOutput("t1_back_idle", inReady, 1'b1);

        $display("[TB] carry-in");
        applyStimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("t2_latency", lat, 4);
        @(posedge clk);
        #1;
        checkOutput("t2_back_idle", inReady, 1'b1);

        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        waitResult(lat);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t3_hold_valid", outValid, 1'b1);
            checkOutput("t3_hold_s", sOut, 16'h0000);
            checkOutput("t3_hold_cout", coutOut, 1'b1);
            checkOutput("t3_hold_in_ready", inReady, 1'b0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3_back_idle", inReady, 1'b1);

        $display("[TB] in_valid ignored while busy");
        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        aIn = 16'h00FF; bIn = 16'h00FF; inValid = 1'b1;
        @(negedge clk);
        checkOutput("t4_in_ready_busy", inReady, 1'b0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        waitResult(lat);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-run");
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mainQ.delete();
        @(negedge clk);
        checkOutput("t5_out_valid", outValid, 1'b0);
        checkOutput("t5_s", sOut, 16'h0000);
        checkOutput("t5_in_ready", inReady, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("t5_latency", lat, 4);
        @(posedge clk);
        #1;

        $display("[TB] reset beats handshake");
        rst = 1'b1; inValid = 1'b1; aIn = 16'h5555; bIn = 16'h5555;
        @(posedge clk);
        #1;
        rst = 1'b0; inValid = 1'b0;
        @(negedge clk);
        checkOutput("t7_in_ready", inReady, 1'b1);
        @(posedge clk);
        #1;

        $display("[TB] signed overflow");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        waitResult(lat);
        @(posedge clk);
        #1;

        $display("[TB] 4-bit sweep");
        for (int i = 0; i < 512; i++) begin : sweep
            exp_t e;
            swA   = 4'(i);
            swB   = 4'(i >> 4);
            swCin = 1'(i >> 8);
            swSum = {1'b0, swA} + {1'b0, swB} + {4'b0, swCin};
            e.s    = {12'h000, swSum[3:0]};
            e.cout = swSum[4];
            e.ovf  = (swA[3] == swB[3]) && (swSum[3] != swA[3]);
            sw1Q.push_back(e);
            sw4Q.push_back(e);
            swValid = 1'b1;
            @(posedge clk);
            #1;
            swValid = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (inReady1 && inReady4) break;
                @(posedge clk);
                #1;
            end
            if (!(inReady1 && inReady4)) begin
                checkOutput("sweep_ready_timeout", {inReady1, inReady4}, 2'b11);
                break;
            end
        end

        repeat (3) @(posedge clk);
        checkOutput("main_queue_empty", mainQ.size(), 0);
        checkOutput("sw1_queue_empty", sw1Q.size(), 0);
        checkOutput("sw4_queue_empty", sw4Q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
